// File: rtl/target_tracker.sv
// target_tracker: matches pixels against a colour window, counts hits per column zone and reports a persistent winning zone; TARGET_TRACKER_OVERLAY_EN enables the video overlay.
// Latency: pixel outputs 1 cycle; frame results N_ZONES+2 cycles after the vsync falling edge.
// Backpressure: none, the pixel stream cannot stall; pixels arriving during RESOLVE/UPDATE are not counted.
module target_tracker #(
   parameter int COLOUR_W   = 8,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int N_ZONES    = 3,
   parameter int R_MIN      = 200,
   parameter int G_MIN      = 60,
   parameter int G_MAX      = 170,
   parameter int B_MAX      = 90,
   parameter int MIN_PIXELS = 400,
   parameter int PERSIST    = 3,
   localparam int CNT_W     = $clog2(H_ACTIVE*V_ACTIVE+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pixel_valid,
   input  logic                vsync,
   input  logic                fast,
   input  logic [COLOUR_W-1:0] red_in,
   input  logic [COLOUR_W-1:0] green_in,
   input  logic [COLOUR_W-1:0] blue_in,
   output logic [COLOUR_W-1:0] red_out,
   output logic [COLOUR_W-1:0] green_out,
   output logic [COLOUR_W-1:0] blue_out,
   output logic                is_target,
   output logic [N_ZONES-1:0]  direction,
   output logic                detected,
   output logic [CNT_W-1:0]    hit_count,
   output logic                frame_done
);

   localparam int ZONE_W = H_ACTIVE / N_ZONES;
   localparam int XW     = $clog2(H_ACTIVE+1) + 1;
   localparam int ZI_W   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
   localparam int PW     = $clog2(PERSIST+1);
   localparam int LAST   = N_ZONES - 1;
   localparam int FIRST_BND = ZONE_W - 1;

   localparam logic [COLOUR_W-1:0] R_MIN_C = R_MIN[COLOUR_W-1:0];
   localparam logic [COLOUR_W-1:0] G_MIN_C = G_MIN[COLOUR_W-1:0];
   localparam logic [COLOUR_W-1:0] G_MAX_C = G_MAX[COLOUR_W-1:0];
   localparam logic [COLOUR_W-1:0] B_MAX_C = B_MAX[COLOUR_W-1:0];
   localparam logic [CNT_W-1:0]    MIN_C   = MIN_PIXELS[CNT_W-1:0];
   localparam logic [PW-1:0]       PERSIST_C = PERSIST[PW-1:0];
   localparam logic [ZI_W-1:0]     LAST_Z  = LAST[ZI_W-1:0];
   localparam logic [XW-1:0]       ZONE_W_C = ZONE_W[XW-1:0];
   localparam logic [XW-1:0]       FIRST_BND_C = FIRST_BND[XW-1:0];

   typedef enum logic [1:0] {ACCUM, RESOLVE, UPDATE} state_t;

   state_t            state;
   logic              match;
   logic              pv_d;
   logic              vsync_d;
   logic              vs_fall;
   logic [XW-1:0]     x_pos;
   logic [XW-1:0]     bnd;
   logic [ZI_W-1:0]   zone_idx;
   logic [CNT_W-1:0]  zone_cnt [N_ZONES];
   logic [ZI_W-1:0]   scan_idx;
   logic [CNT_W-1:0]  max_cnt;
   logic [ZI_W-1:0]   win_idx;
   logic [ZI_W-1:0]   cand_idx;
   logic              cand_vld;
   logic [PW-1:0]     streak;
   logic [PW-1:0]     streak_nxt;
   logic              same_cand;
   logic              commit;
   logic [N_ZONES-1:0] win_onehot;

   assign match = pixel_valid
                  && (red_in >= R_MIN_C)
                  && (green_in >= G_MIN_C) && (green_in <= G_MAX_C)
                  && (blue_in <= B_MAX_C);

   assign vs_fall = vsync_d & ~vsync;

   // Zone index is tracked incrementally; pixels past H_ACTIVE stay in the last zone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_d     <= 1'b0;
         vsync_d  <= 1'b1;
         x_pos    <= '0;
         bnd      <= FIRST_BND_C;
         zone_idx <= '0;
      end else begin
         pv_d    <= pixel_valid;
         vsync_d <= vsync;
         if (pixel_valid) begin
            if (x_pos != '1)
               x_pos <= x_pos + 1'b1;
            if (x_pos == bnd && zone_idx != LAST_Z) begin
               zone_idx <= zone_idx + 1'b1;
               bnd      <= bnd + ZONE_W_C;
            end
         end else if (pv_d) begin
            x_pos    <= '0;
            bnd      <= FIRST_BND_C;
            zone_idx <= '0;
         end
      end
   end

`ifdef TARGET_TRACKER_OVERLAY_EN
   logic on_line;
   always_comb begin
      on_line = 1'b0;
      for (int k = 1; k < N_ZONES; k++) begin
         if (int'(x_pos) == k*ZONE_W-1 || int'(x_pos) == k*ZONE_W)
            on_line = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_out   <= '0;
         green_out <= '0;
         blue_out  <= '0;
         is_target <= 1'b0;
      end else begin
         is_target <= match;
`ifdef TARGET_TRACKER_OVERLAY_EN
         if (match) begin
            red_out   <= '0;
            green_out <= '1;
            blue_out  <= '0;
         end else if (pixel_valid && on_line) begin
            red_out   <= '1;
            green_out <= '1;
            blue_out  <= '1;
         end else begin
            red_out   <= red_in;
            green_out <= green_in;
            blue_out  <= blue_in;
         end
`else
         red_out   <= red_in;
         green_out <= green_in;
         blue_out  <= blue_in;
`endif
      end
   end

   always_comb begin
      same_cand  = cand_vld && (cand_idx == win_idx);
      streak_nxt = PW'(1);
      if (same_cand)
         streak_nxt = (streak == PERSIST_C) ? streak : streak + 1'b1;
      commit     = (streak_nxt == PERSIST_C) || fast;
      win_onehot = N_ZONES'(1) << win_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ACCUM;
         for (int i = 0; i < N_ZONES; i++)
            zone_cnt[i] <= '0;
         scan_idx   <= '0;
         max_cnt    <= '0;
         win_idx    <= '0;
         cand_idx   <= '0;
         cand_vld   <= 1'b0;
         streak     <= '0;
         direction  <= '0;
         detected   <= 1'b0;
         hit_count  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ACCUM: begin
               if (match && zone_cnt[zone_idx] != '1)
                  zone_cnt[zone_idx] <= zone_cnt[zone_idx] + 1'b1;
               if (vs_fall) begin
                  state    <= RESOLVE;
                  scan_idx <= '0;
                  max_cnt  <= '0;
                  win_idx  <= '0;
               end
            end
            RESOLVE: begin
               // Strict greater-than keeps the lowest index on ties.
               if (zone_cnt[scan_idx] > max_cnt) begin
                  max_cnt <= zone_cnt[scan_idx];
                  win_idx <= scan_idx;
               end
               if (scan_idx == LAST_Z)
                  state <= UPDATE;
               else
                  scan_idx <= scan_idx + 1'b1;
            end
            UPDATE: begin
               hit_count  <= max_cnt;
               frame_done <= 1'b1;
               if (max_cnt < MIN_C) begin
                  detected  <= 1'b0;
                  direction <= '0;
                  streak    <= '0;
                  cand_vld  <= 1'b0;
               end else begin
                  streak   <= streak_nxt;
                  cand_idx <= win_idx;
                  cand_vld <= 1'b1;
                  if (commit) begin
                     direction <= win_onehot;
                     detected  <= 1'b1;
                  end
               end
               for (int i = 0; i < N_ZONES; i++)
                  zone_cnt[i] <= '0;
               state <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_target_tracker.sv
// Scoreboard bench for target_tracker: pixel and frame expectations are queued at drive time and compared when the DUT produces them.
module tb_target_tracker;

   typedef struct {
      int         due;
      logic       t;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   typedef struct {
      logic [2:0]  dir;
      logic        det;
      logic [31:0] hc;
   } fr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pixel_valid, vsync, fast;
   logic [7:0]  red_in, green_in, blue_in;
   logic [7:0]  red_out, green_out, blue_out;
   logic        is_target, detected, frame_done;
   logic [2:0]  direction;
   logic [18:0] hit_count;

   logic        s_pv, s_vsync, s_fast;
   logic [7:0]  s_r, s_g, s_b, s_ro, s_go, s_bo;
   logic        s_is_target, s_detected, s_frame_done;
   logic [2:0]  s_direction;
   logic [3:0]  s_hit_count;

   int   n_total = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   frames_seen = 0;
   pix_t pix_q[$];
   fr_t  fq[$];
   pix_t mon_p;
   fr_t  mon_f;

   int         m_cnt[3];
   int         m_cand, m_streak;
   logic       m_cvld, m_det;
   logic [2:0] m_dir;

   target_tracker u_dut (
      .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .vsync(vsync), .fast(fast),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .is_target(is_target), .direction(direction), .detected(detected),
      .hit_count(hit_count), .frame_done(frame_done)
   );

   target_tracker #(.H_ACTIVE(6), .V_ACTIVE(2), .N_ZONES(3), .MIN_PIXELS(1), .PERSIST(1)) u_small (
      .clk(clk), .rst_n(rst_n), .pixel_valid(s_pv), .vsync(s_vsync), .fast(s_fast),
      .red_in(s_r), .green_in(s_g), .blue_in(s_b),
      .red_out(s_ro), .green_out(s_go), .blue_out(s_bo),
      .is_target(s_is_target), .direction(s_direction), .detected(s_detected),
      .hit_count(s_hit_count), .frame_done(s_frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_match(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return (r >= 8'd200) && (g >= 8'd60) && (g <= 8'd170) && (b <= 8'd90);
   endfunction

   function automatic int zone_of(input int x);
      int z;
      z = x / 213;
      return (z > 2) ? 2 : z;
   endfunction

   always @(negedge clk) begin
      while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
         mon_p = pix_q.pop_front();
         check("is_target", {31'd0, is_target}, {31'd0, mon_p.t});
         check("red_out", {24'd0, red_out}, {24'd0, mon_p.r});
         check("green_out", {24'd0, green_out}, {24'd0, mon_p.g});
         check("blue_out", {24'd0, blue_out}, {24'd0, mon_p.b});
      end
      if (frame_done) begin
         frames_seen++;
         check("frame_q_size", fq.size(), 1);
         if (fq.size() > 0) begin
            mon_f = fq.pop_front();
            check("direction", {29'd0, direction}, {29'd0, mon_f.dir});
            check("detected", {31'd0, detected}, {31'd0, mon_f.det});
            check("hit_count", {13'd0, hit_count}, mon_f.hc);
         end
      end
   end

   task automatic drive_pix(input logic v, input int x, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      pix_t e;
      pixel_valid = v;
      red_in = r; green_in = g; blue_in = b;
      e.due = cyc + 1;
      e.t   = v && is_match(r, g, b);
`ifdef TARGET_TRACKER_OVERLAY_EN
      if (e.t) {e.r, e.g, e.b} = {8'h00, 8'hff, 8'h00};
      else if (v && (x == 212 || x == 213 || x == 425 || x == 426)) {e.r, e.g, e.b} = 24'hffffff;
      else {e.r, e.g, e.b} = {r, g, b};
`else
      {e.r, e.g, e.b} = {r, g, b};
`endif
      pix_q.push_back(e);
      if (e.t) m_cnt[zone_of(x)]++;
      @(posedge clk); #1;
   endtask

   task automatic gap();
      for (int i = 0; i < 4; i++) drive_pix(1'b0, 0, 8'd0, 8'd0, 8'd0);
   endtask

   // Lines of up to 200 hits placed at the start of zone z; other pixels fail the red test.
   task automatic zone_hits(input int z, input int total);
      int rem, chunk;
      rem = total;
      while (rem > 0) begin
         chunk = (rem > 200) ? 200 : rem;
         for (int x = 0; x < z*213 + chunk; x++) begin
            if (x >= z*213) drive_pix(1'b1, x, 8'd230, 8'd100, 8'd40);
            else            drive_pix(1'b1, x, 8'd100, 8'd100, 8'd40);
         end
         gap();
         rem -= chunk;
      end
   endtask

   task automatic end_frame();
      fr_t f;
      int mx, w, n, start;
      mx = 0; w = 0; n = 0;
      for (int z = 0; z < 3; z++)
         if (m_cnt[z] > mx) begin mx = m_cnt[z]; w = z; end
      if (mx < 400) begin
         m_det = 1'b0; m_dir = 3'b000; m_streak = 0; m_cvld = 1'b0;
      end else begin
         if (m_cvld && m_cand == w) m_streak = (m_streak < 3) ? m_streak + 1 : 3;
         else begin m_streak = 1; m_cand = w; m_cvld = 1'b1; end
         if (m_streak == 3 || fast) begin m_dir = 3'b001 << w; m_det = 1'b1; end
      end
      f.dir = m_dir; f.det = m_det; f.hc = mx;
      fq.push_back(f);
      for (int z = 0; z < 3; z++) m_cnt[z] = 0;
      start = frames_seen;
      vsync = 1'b0;
      while (frames_seen == start && n < 40) begin @(posedge clk); #1; n++; end
      check("frame_done_seen", frames_seen - start, 1);
      vsync = 1'b1;
      gap();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_red"}, {24'd0, red_out}, 0);
      check({tag, "_green"}, {24'd0, green_out}, 0);
      check({tag, "_blue"}, {24'd0, blue_out}, 0);
      check({tag, "_is_target"}, {31'd0, is_target}, 0);
      check({tag, "_direction"}, {29'd0, direction}, 0);
      check({tag, "_detected"}, {31'd0, detected}, 0);
      check({tag, "_hit_count"}, {13'd0, hit_count}, 0);
      check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
   endtask

   logic [7:0] bnd_tab [6][3] = '{
      '{8'd199, 8'd100, 8'd40}, '{8'd230, 8'd171, 8'd40}, '{8'd230, 8'd100, 8'd91},
      '{8'd200, 8'd60,  8'd90}, '{8'd200, 8'd170, 8'd0},  '{8'd255, 8'd59,  8'd0}
   };

   initial begin
      int n;
      rst_n = 1'b0; pixel_valid = 1'b0; vsync = 1'b1; fast = 1'b0;
      red_in = 0; green_in = 0; blue_in = 0;
      s_pv = 1'b0; s_vsync = 1'b1; s_fast = 1'b0; s_r = 0; s_g = 0; s_b = 0;
      for (int z = 0; z < 3; z++) m_cnt[z] = 0;
      m_cand = 0; m_streak = 0; m_cvld = 1'b0; m_det = 1'b0; m_dir = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      gap();

      fast = 1'b1;
      zone_hits(0, 500);
      end_frame();

      fast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         zone_hits(2, 450);
         end_frame();
      end

      for (int i = 0; i < 6; i++) drive_pix(1'b1, i, bnd_tab[i][0], bnd_tab[i][1], bnd_tab[i][2]);
      gap();
      end_frame();

      zone_hits(2, 399);
      end_frame();

      fast = 1'b1;
      zone_hits(0, 450);
      zone_hits(1, 450);
      end_frame();

      zone_hits(1, 300);
      check("pre_reset_detected", {31'd0, detected}, {31'd0, m_det});
      pix_q.delete();
      #2 rst_n = 1'b0;
      #1 check_zero("mid_reset");
      for (int z = 0; z < 3; z++) m_cnt[z] = 0;
      m_cand = 0; m_streak = 0; m_cvld = 1'b0; m_det = 1'b0; m_dir = 3'b000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      gap();
      zone_hits(1, 420);
      end_frame();

      // Reduced-size instance: one over-long line of hits drives zone 2 past its 4-bit ceiling.
      for (int i = 0; i < 30; i++) begin
         s_pv = 1'b1; s_r = 8'd230; s_g = 8'd100; s_b = 8'd40;
         @(posedge clk); #1;
         if (i == 0) check("small_is_target", {31'd0, s_is_target}, 1);
      end
      s_pv = 1'b0; s_r = 0; s_g = 0; s_b = 0;
      repeat (4) @(posedge clk);
      #1;
      s_vsync = 1'b0;
      n = 0;
      while (!s_frame_done && n < 40) begin @(posedge clk); #1; n++; end
      check("small_frame_done", {31'd0, s_frame_done}, 1);
      check("small_hit_count_sat", {28'd0, s_hit_count}, 15);
      check("small_direction", {29'd0, s_direction}, 4);
      check("small_detected", {31'd0, s_detected}, 1);
      s_vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      check("frames_pending", fq.size(), 0);
      check("pixels_pending", pix_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
